// File: rtl/ifu_fetch.sv
// Single-issue instruction fetch unit: one outstanding imem request, issues the
// instruction to decode, then redirects from the next-PC select on commit.
//   state | meaning
//   BOOT  | one idle cycle after reset
//   REQ   | fetch request offered on imem
//   WAIT  | awaiting imem response, timeout timer running
//   ISSUE | instruction offered to decode
//   EXEC  | awaiting commit from execute
//   HALT  | fault recorded, absorbing until reset
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  input  logic        commit_valid,
  input  logic [1:0]  npc_ctl,
  input  logic [63:0] alu_rst,
  input  logic [63:0] pc_branch,
  output logic [63:0] instret,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [63:0] fault_pc
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic [63:0] instret_q, instret_d;
  logic [1:0]  fault_cause_q, fault_cause_d;
  logic [63:0] fault_pc_q, fault_pc_d;
  logic [15:0] tmr_q, tmr_d;
  logic [63:0] target;

  // Jump targets drop bit 0; only bit 1 is checked for misalignment.
  always_comb begin
    case (npc_ctl)
      2'b01:   target = alu_rst & ~64'd1;
      2'b10:   target = pc_branch;
      default: target = pc_q + 64'd4;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    instret_d     = instret_q;
    fault_cause_d = fault_cause_q;
    fault_pc_d    = fault_pc_q;
    tmr_d         = tmr_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          tmr_d   = TMR_LOAD;
        end
      end
      S_WAIT: begin
        // A response in the terminal-count cycle takes priority over timeout.
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d       = S_HALT;
            fault_cause_d = 2'b10;
            fault_pc_d    = pc_q;
          end else begin
            state_d   = S_ISSUE;
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
          end
        end else if (tmr_q == 16'd0) begin
          state_d       = S_HALT;
          fault_cause_d = 2'b11;
          fault_pc_d    = pc_q;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_ISSUE: begin
        if (inst_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (commit_valid) begin
          instret_d = instret_q + 64'd1;
          if (target[1]) begin
            state_d       = S_HALT;
            fault_cause_d = 2'b01;
            fault_pc_d    = target;
          end else begin
            state_d = S_REQ;
            pc_d    = target;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      instret_q     <= '0;
      fault_cause_q <= '0;
      fault_pc_q    <= '0;
      tmr_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      instret_q     <= instret_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q    <= fault_pc_d;
      tmr_q         <= tmr_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_ISSUE);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign opcode         = inst_q[6:0];
  assign func3          = inst_q[14:12];
  assign func7          = inst_q[31:25];
  assign instret        = instret_q;
  assign fault          = (state_q == S_HALT);
  assign fault_cause    = fault_cause_q;
  assign fault_pc       = fault_pc_q;

endmodule
